// File: rtl/gpio_in.sv
// ---------------------------------------------------------------------------
// gpio_in
//
// Input-side GPIO block. External pins are synchronised (two flops per pin),
// optionally debounced, and the accepted levels drive sticky rising/falling
// edge flags. The flags are masked by IEN and OR-reduced into a registered,
// level-sensitive interrupt request. The CPU reaches the registers over the
// shared I/O bus. Register reads are combinational. The data bus is tri-stated
// whenever this block is not being read.
//
// Register map (register index = id[2:0], selected when id[5:3] == BASE_ID[5:3]):
//   0 PIN  RO   debounced level
//   1 RISE W1C  sticky rising-edge flags
//   2 FALL W1C  sticky falling-edge flags
//   3 IEN  RW   interrupt mask
//   4 RAW  RO   synchronised, undebounced pins
//   5..7   RO   read as 8'h00
//
// Build option:
//   GPIO_IN_DEBOUNCE_EN  defined   : each pin needs DEB_CYCLES stable cycles
//                                    before a new level is accepted
//                        undefined : the accepted level follows the
//                                    synchroniser output every cycle
//
// Ports:
//   clk      in   1      system clock; all logic runs on posedge
//   rst      in   1      synchronous reset, active-high
//   din      in   16     CPU write data; only din[7:0] is used
//   id       in   6      CPU I/O register id
//   read     in   1      I/O read strobe
//   write    in   1      I/O write strobe
//   dout     out  16     {8'h00, reg} while read && selected, else 16'hzzzz
//   pins_in  in   NPINS  asynchronous external pins
//   irq      out  1      registered level interrupt request
// ---------------------------------------------------------------------------
module gpio_in #(
  parameter int unsigned NPINS      = 8,
  parameter int unsigned DEB_CYCLES = 16,
  parameter logic [5:0]  BASE_ID    = 6'h28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      din,
  input  logic [5:0]       id,
  input  logic             read,
  input  logic             write,
  output logic [15:0]      dout,
  input  logic [NPINS-1:0] pins_in,
  output logic             irq
);

  localparam logic [2:0] IDX_PIN  = 3'd0;
  localparam logic [2:0] IDX_RISE = 3'd1;
  localparam logic [2:0] IDX_FALL = 3'd2;
  localparam logic [2:0] IDX_IEN  = 3'd3;
  localparam logic [2:0] IDX_RAW  = 3'd4;

  // Zero-extend a per-pin vector to the 8-bit register width.
  function automatic logic [7:0] widen(input logic [NPINS-1:0] v);
    logic [7:0] r;
    r = 8'h00;
    r[NPINS-1:0] = v;
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Bus decode
  // -------------------------------------------------------------------------
  logic       sel;
  logic [2:0] idx;
  logic       wr_rise;
  logic       wr_fall;
  logic       wr_ien;

  assign sel     = (id[5:3] == BASE_ID[5:3]);
  assign idx     = id[2:0];
  assign wr_rise = write && sel && (idx == IDX_RISE);
  assign wr_fall = write && sel && (idx == IDX_FALL);
  assign wr_ien  = write && sel && (idx == IDX_IEN);

  // Bits of din above the pin count have no register to land in.
  logic unused_din;
  assign unused_din = ^din[15:NPINS];

  // -------------------------------------------------------------------------
  // Synchroniser (s1 -> s2); s2 is the RAW view
  // -------------------------------------------------------------------------
  logic [NPINS-1:0] s1_q;
  logic [NPINS-1:0] s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= pins_in;
      s2_q <= s1_q;
    end
  end

  // -------------------------------------------------------------------------
  // Level qualification (stab)
  // -------------------------------------------------------------------------
  logic [NPINS-1:0] stab_q;
  logic [NPINS-1:0] stab_d;

`ifdef GPIO_IN_DEBOUNCE_EN
  // One extra bit beyond what DEB_CYCLES-1 needs. The counter restarts at
  // the terminal count, so it never wraps.
  localparam int unsigned CNT_W = $clog2(DEB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q [NPINS];
  logic [CNT_W-1:0] cnt_d [NPINS];

  // Any cycle where s2 agrees with the accepted level restarts the count.
  // A glitch shorter than DEB_CYCLES therefore never reaches stab.
  always_comb begin
    stab_d = stab_q;
    cnt_d  = '{default: '0};
    for (int i = 0; i < NPINS; i++) begin
      if (s2_q[i] != stab_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stab_d[i] = s2_q[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Without debouncing the accepted level is s2 delayed by one cycle.
  localparam int unsigned unused_deb_cycles = DEB_CYCLES;

  always_comb begin
    stab_d = s2_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      stab_q <= '0;
    end else begin
      stab_q <= stab_d;
    end
  end

  // -------------------------------------------------------------------------
  // Edge flags, mask and interrupt
  // -------------------------------------------------------------------------
  logic [NPINS-1:0] rise_q, rise_d;
  logic [NPINS-1:0] fall_q, fall_d;
  logic [NPINS-1:0] ien_q,  ien_d;
  logic             irq_q,  irq_d;
  logic [NPINS-1:0] rise_set;
  logic [NPINS-1:0] fall_set;
  logic [NPINS-1:0] rise_clr;
  logic [NPINS-1:0] fall_clr;

  // Flags are raised on the same edge that updates stab, so a flag becomes
  // visible together with the new PIN value.
  assign rise_set = stab_d & ~stab_q;
  assign fall_set = ~stab_d & stab_q;
  assign rise_clr = wr_rise ? din[NPINS-1:0] : '0;
  assign fall_clr = wr_fall ? din[NPINS-1:0] : '0;

  always_comb begin
    // The set term is OR-ed in after the clear. An event that coincides
    // with a W1C write is therefore kept.
    rise_d = (rise_q & ~rise_clr) | rise_set;
    fall_d = (fall_q & ~fall_clr) | fall_set;
    ien_d  = wr_ien ? din[NPINS-1:0] : ien_q;
    // Built from registered flags and mask. irq trails any change by one cycle.
    irq_d  = |((rise_q | fall_q) & ien_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= '0;
      fall_q <= '0;
      ien_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
      ien_q  <= ien_d;
      irq_q  <= irq_d;
    end
  end

  assign irq = irq_q;

  // -------------------------------------------------------------------------
  // Read mux: combinational from current state, so a read alongside a
  // write to the same index returns the pre-write value.
  // -------------------------------------------------------------------------
  logic [7:0] rdata;

  always_comb begin
    rdata = 8'h00;
    case (idx)
      IDX_PIN:  rdata = widen(stab_q);
      IDX_RISE: rdata = widen(rise_q);
      IDX_FALL: rdata = widen(fall_q);
      IDX_IEN:  rdata = widen(ien_q);
      IDX_RAW:  rdata = widen(s2_q);
      default:  rdata = 8'h00;
    endcase
  end

  assign dout = (read && sel) ? {8'h00, rdata} : 16'hzzzz;

endmodule

// File: tb/tb_gpio_in.sv
module tb_gpio_in;

`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int LAT = 16 + 2;
`else
  localparam int LAT = 3;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] din;
  logic [5:0]  id;
  logic        read;
  logic        write;
  logic [7:0]  pins;
  tri1  [15:0] dout_w;
  wire         irq;

  int passed = 0;
  int total  = 0;

  logic [15:0] exp_q [$];
  string       tag_q [$];

  gpio_in #(.NPINS(8), .DEB_CYCLES(16), .BASE_ID(6'h28)) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .id      (id),
    .read    (read),
    .write   (write),
    .dout    (dout_w),
    .pins_in (pins),
    .irq     (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmp(input logic [15:0] got);
    logic [15:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    total++;
    assert (got === e) passed++;
    else $error("FAIL %s observed=%h expected=%h", t, got, e);
  endtask

  task automatic rd(input logic [5:0] a, input logic [15:0] e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
    id   = a;
    read = 1'b1;
    #1;
    cmp(dout_w);
    read = 1'b0;
  endtask

  // A released bus floats; tri1 resolves it to all ones.
  task automatic rd_float(input logic [5:0] a, input string t);
    logic [15:0] g;
    exp_q.push_back(16'hFFFF);
    tag_q.push_back(t);
    id   = a;
    read = 1'b1;
    #1;
    g = (dout_w === 16'hzzzz) ? 16'hFFFF : dout_w;
    cmp(g);
    read = 1'b0;
  endtask

  task automatic chk_irq(input logic e, input string t);
    exp_q.push_back({15'h0, e});
    tag_q.push_back(t);
    #0;
    cmp({15'h0, irq});
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    id    = a;
    din   = d;
    write = 1'b1;
    step(1);
    write = 1'b0;
  endtask

  initial begin
    rst = 1'b1; din = '0; id = '0; read = 1'b0; write = 1'b0; pins = 8'h00;
    step(3);
    rst = 1'b0;
    step(1);

    // Reset state
    for (int i = 0; i < 8; i++) begin
      logic [5:0] a;
      a = 6'h28 + 6'(i);
      rd(a, 16'h0000, $sformatf("reset_reg%0d", i));
    end
    chk_irq(1'b0, "reset_irq");
    rd_float(6'h20, "deselect_float");

    // Rising edge with mask enabled
    wr(6'h2B, 16'h0001);
    rd(6'h2B, 16'h0001, "ien_rw");
    pins = 8'h01;
    step(LAT - 1);
    rd(6'h28, 16'h0000, "pin_not_yet");
    rd(6'h2C, 16'h0001, "raw_early");
    step(1);
    rd(6'h28, 16'h0001, "pin_latency");
    rd(6'h29, 16'h0001, "rise_set");
    chk_irq(1'b0, "irq_not_yet");
    step(1);
    chk_irq(1'b1, "irq_asserted");

`ifdef GPIO_IN_DEBOUNCE_EN
    // Short glitch on pin 3 is visible on RAW only
    pins = 8'h09;
    step(2);
    rd(6'h2C, 16'h0009, "raw_glitch");
    step(8);
    pins = 8'h01;
    step(LAT + 2);
    rd(6'h28, 16'h0001, "glitch_pin");
    rd(6'h29, 16'h0001, "glitch_rise");
    rd(6'h2A, 16'h0000, "glitch_fall");
`else
    // Pin 7 follows with three edges of latency in both directions
    pins = 8'h81;
    step(2);
    rd(6'h28, 16'h0001, "p7_not_yet");
    step(1);
    rd(6'h28, 16'h0081, "p7_pin");
    rd(6'h29, 16'h0081, "p7_rise");
    pins = 8'h01;
    step(2);
    rd(6'h2A, 16'h0000, "p7_fall_not_yet");
    step(1);
    rd(6'h2A, 16'h0080, "p7_fall");
    rd(6'h28, 16'h0001, "p7_pin_low");
    wr(6'h29, 16'h0080);
    wr(6'h2A, 16'h0080);
    rd(6'h29, 16'h0001, "p7_rise_clr");
    rd(6'h2A, 16'h0000, "p7_fall_clr");
`endif

    // Writes to read-only registers are ignored
    wr(6'h28, 16'h00FF);
    wr(6'h2C, 16'h00FF);
    rd(6'h28, 16'h0001, "ro_pin");
    rd(6'h2C, 16'h0001, "ro_raw");

    // Falling edge, then W1C colliding with a new rising event
    pins = 8'h00;
    step(LAT);
    rd(6'h28, 16'h0000, "pin_low");
    rd(6'h2A, 16'h0001, "fall_set");
    wr(6'h2A, 16'h0001);
    rd(6'h2A, 16'h0000, "fall_clr");
    pins = 8'h01;
    step(LAT - 1);
    id = 6'h29; din = 16'h0001; write = 1'b1;
    step(1);
    write = 1'b0;
    rd(6'h28, 16'h0001, "collide_pin");
    rd(6'h29, 16'h0001, "collide_rise_kept");

    // Clear with no event; read alongside the write sees the old value
    id = 6'h29; din = 16'h0001; write = 1'b1;
    rd(6'h29, 16'h0001, "rd_during_wr");
    step(1);
    write = 1'b0;
    rd(6'h29, 16'h0000, "rise_cleared");
    chk_irq(1'b1, "irq_lags_clear");
    step(1);
    chk_irq(1'b0, "irq_dropped");

    // Reset in the middle of a pin1 transition
    pins = 8'h03;
    step(12);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    rd(6'h28, 16'h0000, "rst_pin");
    rd(6'h2B, 16'h0000, "rst_ien");
    rd(6'h29, 16'h0000, "rst_rise");
    step(LAT - 1);
    rd(6'h28, 16'h0000, "requal_not_yet");
    step(1);
    rd(6'h28, 16'h0003, "requal_pin");
    rd(6'h29, 16'h0003, "requal_rise");
    chk_irq(1'b0, "irq_masked");
    wr(6'h2B, 16'h0002);
    chk_irq(1'b0, "irq_mask_lag");
    step(1);
    chk_irq(1'b1, "irq_mask_on");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
